// File: rtl/exc_ctrl.sv
// Exception controller: detects MEM-stage events, reports them to CP0,
// flushes the pipeline for one cycle, then redirects fetch until acknowledged.
module exc_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_ds_i,
  input  logic [31:0] mem_bad_addr_i,
  input  logic [7:0]  exc_vec_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] cur_pc_o,
  output logic        in_ds_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  input  logic        redirect_ack_i,
  output logic        busy_o
);
  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

  localparam logic [31:0] EXC_VECTOR = 32'hBFC00380;

  state_t      state;
  logic        int_pend;
  logic        ev_any;
  logic [31:0] ev_code;
  logic [31:0] ev_bad;
  logic [31:0] ev_tgt;
  logic        unused_bits;

  assign int_pend    = |(cause_i[15:8] & status_i[15:8]) & status_i[0] & ~status_i[1];
  assign ev_any      = int_pend | (|exc_vec_i);
  assign unused_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

  // Priority encode: interrupt, AdEL-fetch, RI, Ov, Syscall, Break, AdEL-load, AdES, Eret
  always_comb begin
    ev_code = 32'h0;
    ev_bad  = 32'h0;
    ev_tgt  = EXC_VECTOR;
    if (int_pend)          ev_code = 32'h1;
    else if (exc_vec_i[0]) begin ev_code = 32'h4; ev_bad = mem_pc_i; end
    else if (exc_vec_i[5]) ev_code = 32'ha;
    else if (exc_vec_i[6]) ev_code = 32'hc;
    else if (exc_vec_i[3]) ev_code = 32'h8;
    else if (exc_vec_i[4]) ev_code = 32'h9;
    else if (exc_vec_i[1]) begin ev_code = 32'h4; ev_bad = mem_bad_addr_i; end
    else if (exc_vec_i[2]) begin ev_code = 32'h5; ev_bad = mem_bad_addr_i; end
    else if (exc_vec_i[7]) begin ev_code = 32'he; ev_tgt = epc_i; end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      excepttype_o     <= 32'h0;
      cur_pc_o         <= 32'h0;
      in_ds_o          <= 1'b0;
      bad_addr_o       <= 32'h0;
      flush_o          <= 1'b0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= 32'h0;
      busy_o           <= 1'b0;
    end else if (!stall_i) begin
      case (state)
        IDLE: if (mem_valid_i && ev_any) begin
          state         <= FLUSH;
          excepttype_o  <= ev_code;
          cur_pc_o      <= mem_pc_i;
          in_ds_o       <= mem_in_ds_i;
          bad_addr_o    <= ev_bad;
          redirect_pc_o <= ev_tgt;
          flush_o       <= 1'b1;
          busy_o        <= 1'b1;
        end
        FLUSH: begin
          state            <= REDIRECT;
          excepttype_o     <= 32'h0;
          flush_o          <= 1'b0;
          redirect_valid_o <= 1'b1;
        end
        REDIRECT: if (redirect_ack_i) begin
          state            <= IDLE;
          redirect_valid_o <= 1'b0;
          busy_o           <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-low; asserted (0) forces reset state immediately, independent of clk.
REQ-003 stall_i  in  1  pipeline stall; when 1, FSM and all registered outputs hold.
REQ-004 mem_valid_i  in  1  MEM-stage instruction valid.
REQ-005 mem_pc_i  in  32  MEM-stage instruction PC.
REQ-006 mem_in_ds_i  in  1  MEM-stage instruction sits in a delay slot.
REQ-007 mem_bad_addr_i  in  32  faulting data address from load/store.
REQ-008 exc_vec_i  in  8  event flags: [0] AdEL-fetch, [1] AdEL-load, [2] AdES, [3] Syscall, [4] Break, [5] RI, [6] Ov, [7] Eret.
REQ-009 status_i, cause_i, epc_i  in  32 each  current CP0 Status/Cause/EPC values.
REQ-010 excepttype_o  out  32  event code to CP0 register file.
REQ-011 cur_pc_o  out  32  latched faulting PC to CP0.
REQ-012 in_ds_o  out  1  latched delay-slot flag to CP0.
REQ-013 bad_addr_o  out  32  latched bad address to CP0.
REQ-014 flush_o  out  1  flush all pipeline stages.
REQ-015 redirect_valid_o  out  1  redirect request to fetch.
REQ-016 redirect_pc_o  out  32  redirect target.
REQ-017 redirect_ack_i  in  1  fetch accepted redirect.
REQ-018 busy_o  out  1  controller is not in IDLE.

Function
REQ-019 The FSM SHALL have three states: IDLE, FLUSH, REDIRECT.
REQ-020 Interrupt pending SHALL be: |(cause_i[15:8] & status_i[15:8]) & status_i[0] & ~status_i[1].
REQ-021 Priority, highest first: interrupt, AdEL-fetch, RI, Ov, Syscall, Break, AdEL-load, AdES, Eret.
REQ-022 Codes: interrupt 32'h1, AdEL 32'h4, AdES 32'h5, Syscall 32'h8, Break 32'h9, RI 32'ha, Ov 32'hc, Eret 32'he.
REQ-023 In IDLE, when mem_valid_i=1, stall_i=0 and any event (REQ-020 or exc_vec_i!=0) is present, the block SHALL latch code, mem_pc_i, mem_in_ds_i and bad address, then move to FLUSH next edge.
REQ-024 Bad address SHALL be mem_pc_i for AdEL-fetch, mem_bad_addr_i for AdEL-load/AdES, 0 otherwise.
REQ-025 Redirect target SHALL be latched at detection: epc_i for Eret, 32'hBFC00380 for all others.
REQ-026 In FLUSH, flush_o=1 and excepttype_o=latched code; with stall_i=0 the FSM SHALL move to REDIRECT next edge, giving exactly one unstalled FLUSH cycle per event.
REQ-027 excepttype_o SHALL be 0 in every state other than FLUSH.
REQ-028 In REDIRECT, redirect_valid_o=1 with stable redirect_pc_o until redirect_ack_i=1 is sampled; then return to IDLE.
REQ-029 Ack in the same cycle as stall_i=1 SHALL be ignored.
REQ-030 Events arriving while busy_o=1 SHALL be ignored; a still-pending interrupt is re-evaluated in IDLE.
REQ-031 Latency detection edge -> flush_o high: 1 cycle; flush_o -> redirect_valid_o: 1 cycle (unstalled).
REQ-032 mem_valid_i=0 SHALL suppress all detection, including interrupts.

Reset
REQ-033 On rst=0: state IDLE; excepttype_o, cur_pc_o, bad_addr_o, redirect_pc_o = 32'h0; in_ds_o, flush_o, redirect_valid_o, busy_o = 0.
REQ-034 Reset asserted in FLUSH or REDIRECT SHALL abort the sequence without an extra flush or redirect.

Verification
REQ-035 exc_vec_i=8'h08, mem_pc_i=32'hBFC00100, valid -> next cycle excepttype_o=32'h8, flush_o=1; then redirect_valid_o=1, redirect_pc_o=32'hBFC00380.
REQ-036 exc_vec_i=8'h02, mem_bad_addr_i=32'h80000003, mem_in_ds_i=1 -> excepttype_o=32'h4, bad_addr_o=32'h80000003, in_ds_o=1.
REQ-037 status_i=32'h0000FF01, cause_i[15:8]=8'h80, exc_vec_i=8'h40 -> excepttype_o=32'h1; with status_i[1]=1 instead -> excepttype_o=32'hc.
REQ-038 exc_vec_i=8'h80, epc_i=32'hBFC00200 -> excepttype_o=32'he, redirect_pc_o=32'hBFC00200; ack withheld 3 cycles -> redirect_valid_o held 3 cycles, return to IDLE after ack.
REQ-039 stall_i=1 during FLUSH for 2 cycles -> flush_o and excepttype_o held, state unchanged, REDIRECT entered one edge after stall_i drops.
REQ-040 rst=0 pulsed mid-REDIRECT -> all outputs 0 immediately, busy_o=0; a new Syscall afterwards is handled normally.
